// File: rtl/alu_seq_exec.sv
// ALU execute stage with a valid/ready request/response pair.
// Single-cycle ops finish at once; shifts iterate SHIFT_STEP bits per cycle (no barrel shifter).
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;
endpackage

// state | meaning
// IDLE  | waiting for a request, req_ready_o=1 unless flushing
// SHIFT | iterating a shift, rem bits still to go
// DONE  | result_o/zero_o held with rsp_valid_o=1 until consumed
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  alu_op_e         alu_op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            busy_o
);

    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e          state;
    alu_op_e         shift_op;
    logic [XLEN-1:0] work;
    logic [SW-1:0]   rem;
    logic [SW-1:0]   step;
    logic [SW-1:0]   rem_next;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shifted;
    logic            is_shift;
    logic            accept;

    assign shamt       = operand_b_i[SW-1:0];
    assign is_shift    = (alu_op_i == ALU_SLL) || (alu_op_i == ALU_SRL) || (alu_op_i == ALU_SRA);
    assign req_ready_o = ~flush_i & ((state == IDLE) | ((state == DONE) & rsp_ready_i));
    assign accept      = req_valid_i & req_ready_o;
    assign busy_o      = (state != IDLE);

    always_comb begin
        alu_res = operand_a_i + operand_b_i;
        case (alu_op_i)
            ALU_SUB:  alu_res = operand_a_i - operand_b_i;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(operand_a_i) < $signed(operand_b_i))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (operand_a_i < operand_b_i)};
            ALU_XOR:  alu_res = operand_a_i ^ operand_b_i;
            ALU_OR:   alu_res = operand_a_i | operand_b_i;
            ALU_AND:  alu_res = operand_a_i & operand_b_i;
            // only reached with shamt == 0; nonzero shifts go through SHIFT
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = operand_a_i;
            default:  alu_res = operand_a_i + operand_b_i;
        endcase
    end

    // last step may be partial when rem is not a multiple of SHIFT_STEP
    always_comb begin
        if ({1'b0, rem} < (SW+1)'(SHIFT_STEP))
            step = rem;
        else
            step = SW'(SHIFT_STEP);
        rem_next = rem - step;
        case (shift_op)
            ALU_SLL: shifted = work << step;
            ALU_SRA: shifted = $signed(work) >>> step;
            default: shifted = work >> step;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            shift_op    <= ALU_SLL;
            work        <= '0;
            rem         <= '0;
            rsp_valid_o <= 1'b0;
            result_o    <= '0;
            zero_o      <= 1'b0;
        end else if (flush_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
        end else if (accept) begin
            if (is_shift && (shamt != '0)) begin
                state       <= SHIFT;
                shift_op    <= alu_op_i;
                work        <= operand_a_i;
                rem         <= shamt;
                rsp_valid_o <= 1'b0;
            end else begin
                state       <= DONE;
                result_o    <= alu_res;
                zero_o      <= (alu_res == '0);
                rsp_valid_o <= 1'b1;
            end
        end else begin
            case (state)
                SHIFT: begin
                    work <= shifted;
                    rem  <= rem_next;
                    if (rem_next == '0) begin
                        state       <= DONE;
                        result_o    <= shifted;
                        zero_o      <= (shifted == '0);
                        rsp_valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: SHIFT_STEP=1 instance carries most scenarios,
// a SHIFT_STEP=4 instance checks multi-bit stepping.
module tb_alu_seq_exec;
    import alu_pkg::*;

    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0, flush = 0, rsp_ready = 0;
    alu_op_e     alu_op = ALU_ADD;
    logic [31:0] operand_a = 0, operand_b = 0;
    logic        req_ready, rsp_valid, zero, busy;
    logic [31:0] result;

    logic        req_valid4 = 0, rsp_ready4 = 0;
    alu_op_e     alu_op4 = ALU_ADD;
    logic [31:0] operand_a4 = 0, operand_b4 = 0;
    logic        req_ready4, rsp_valid4, zero4, busy4;
    logic [31:0] result4;

    int n_cmp = 0;
    int n_fail = 0;
    int cycle_cnt = 0;
    logic [31:0] exp_q[$];

    alu_seq_exec #(.XLEN(32), .SHIFT_STEP(1)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .alu_op_i(alu_op), .operand_a_i(operand_a), .operand_b_i(operand_b), .flush_i(flush),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .result_o(result), .zero_o(zero),
        .busy_o(busy)
    );

    alu_seq_exec #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid4), .req_ready_o(req_ready4),
        .alu_op_i(alu_op4), .operand_a_i(operand_a4), .operand_b_i(operand_b4), .flush_i(1'b0),
        .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready4), .result_o(result4), .zero_o(zero4),
        .busy_o(busy4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: a response is consumed at the next rising edge when valid & ready & !flush.
    always @(negedge clk) begin
        if (!rst && !flush && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_rsp: result=%08h with no expected entry", result);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                n_cmp++;
                if (result !== e) begin
                    n_fail++;
                    $display("FAIL rsp_result: got %08h expected %08h", result, e);
                end
                n_cmp++;
                if (zero !== (e == 32'd0)) begin
                    n_fail++;
                    $display("FAIL rsp_zero: got %0b expected %0b (result %08h)", zero, (e == 32'd0), e);
                end
            end
        end
    end

    function automatic logic [31:0] model(alu_op_e op, logic [31:0] a, logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $unsigned($signed(a) >>> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Present a request until accepted; scrambles operands afterwards so late changes are visible.
    task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push);
        bit ok;
        ok = 0;
        req_valid = 1; alu_op = op; operand_a = a; operand_b = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                if (push) exp_q.push_back(exp);
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL issue_timeout: op=%0d never accepted", op);
        end
        sync();
        req_valid = 0;
        alu_op = alu_op_e'(4'($urandom_range(0, 9)));
        operand_a = $urandom; operand_b = $urandom;
    endtask

    // Called right after the accept edge; returns on the negedge where rsp_valid is seen.
    task automatic wait_rsp(output int lat, output bit busy_ok);
        bit seen;
        lat = 1; busy_ok = 1; seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) busy_ok = 0;
            if (rsp_valid) begin
                seen = 1;
                break;
            end
            sync();
            lat++;
        end
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL rsp_timeout: rsp_valid never asserted");
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) sync();
        rst = 0;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, result, zero, busy} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b result=%08h zero=%0b busy=%0b required all 0",
                     rsp_valid, result, zero, busy);
        end
        n_cmp++;
        if (req_ready !== 1'b1 || req_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b/%0b required 1/1", req_ready, req_ready4);
        end
        sync();
    endtask

    task automatic test_add_wrap();
        int lat; bit bok;
        rsp_ready = 1;
        issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        wait_rsp(lat, bok);
        n_cmp++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL add_latency: got %0d required 1", lat);
        end
        n_cmp++;
        if (zero !== 1'b1 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL add_wrap: result=%08h zero=%0b required 00000000/1", result, zero);
        end
        sync();
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [10] = '{4'd3, 4'd4, 4'd1, 4'd5, 4'd8, 4'd9, 4'd0, 4'd12, 4'd3, 4'd4};
        logic [31:0] as  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'hF0F0_1234, 32'hF000_000F,
                                  32'hFF00_FF00, 32'h7FFF_FFFF, 32'd3, 32'd1, 32'd1};
        logic [31:0] bs  [10] = '{32'd1, 32'd1, 32'd7, 32'h0FF0_1234, 32'h0000_0F00,
                                  32'h0FF0_0FF0, 32'd1, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex  [10] = '{32'd1, 32'd0, 32'hFFFF_FFFE, 32'hFF00_0000, 32'hF000_0F0F,
                                  32'h0F00_0F00, 32'h8000_0000, 32'd7, 32'd0, 32'd1};
        int lat; bit bok;
        rsp_ready = 1;
        for (int i = 0; i < 10; i++) begin
            issue(alu_op_e'(ops[i]), as[i], bs[i], ex[i], 1);
            wait_rsp(lat, bok);
            n_cmp++;
            if (lat !== 1) begin
                n_fail++;
                $display("FAIL alu_latency[%0d]: got %0d required 1", i, lat);
            end
            sync();
        end
    endtask

    task automatic test_shift();
        alu_op_e     ops [6] = '{ALU_SRA, ALU_SRL, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SRL};
        logic [31:0] as  [6] = '{32'h8000_0000, 32'h1234_5678, 32'd1, 32'hF000_0000,
                                 32'h4000_0000, 32'h8000_0000};
        logic [31:0] bs  [6] = '{32'd31, 32'h20, 32'hFFFF_FFE3, 32'd4, 32'd30, 32'd31};
        logic [31:0] ex  [6] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'd8, 32'h0F00_0000, 32'd1, 32'd1};
        int          el  [6] = '{32, 1, 4, 5, 31, 32};
        int lat; bit bok;
        rsp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], ex[i], 1);
            wait_rsp(lat, bok);
            n_cmp++;
            if (lat !== el[i]) begin
                n_fail++;
                $display("FAIL shift_latency[%0d]: got %0d required %0d", i, lat, el[i]);
            end
            n_cmp++;
            if (!bok) begin
                n_fail++;
                $display("FAIL shift_busy[%0d]: busy_o dropped while op in flight, required 1", i);
            end
            sync();
        end
    endtask

    task automatic test_hold();
        int lat; bit bok; int bad;
        rsp_ready = 0;
        issue(ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);
        wait_rsp(lat, bok);
        req_valid = 1; alu_op = ALU_XOR; operand_a = 32'h0000_F0F0; operand_b = 32'h0000_FFFF;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            sync();
            @(negedge clk);
            if (rsp_valid !== 1'b1 || result !== 32'h0F00_0F00 || req_ready !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d bad cycles (valid=%0b result=%08h ready=%0b) required 0",
                     bad, rsp_valid, result, req_ready);
        end
        sync();
        rsp_ready = 1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_same_cycle_ready: got %0b required 1", req_ready);
        end
        exp_q.push_back(32'h0000_0F0F);
        sync();
        req_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || result !== 32'h0000_0F0F) begin
            n_fail++;
            $display("FAIL hold_next_result: valid=%0b result=%08h required 1/00000f0f",
                     rsp_valid, result);
        end
        sync();
    endtask

    task automatic test_back_to_back();
        alu_op_e pool [7] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND};
        int c0;
        rsp_ready = 1;
        c0 = cycle_cnt;
        for (int i = 0; i < 8; i++) begin
            alu_op_e op; logic [31:0] a, b;
            op = pool[$urandom_range(0, 6)];
            a = $urandom; b = $urandom;
            if (i == 3) b = a;
            issue(op, a, b, model(op, a, b), 1);
        end
        n_cmp++;
        if (cycle_cnt - c0 !== 8) begin
            n_fail++;
            $display("FAIL b2b_throughput: 8 ops took %0d cycles required 8", cycle_cnt - c0);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) sync();
    endtask

    task automatic test_flush();
        int lat; bit bok; int seen;
        rsp_ready = 1;
        issue(ALU_SRL, 32'hFFFF_FFFF, 32'd20, 32'd0, 0);
        repeat (3) sync();
        flush = 1;
        req_valid = 1; alu_op = ALU_ADD; operand_a = 32'd1; operand_b = 32'd1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got %0b required 0", req_ready);
        end
        sync();
        flush = 0; req_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_shift_idle: busy=%0b valid=%0b required 0/0", busy, rsp_valid);
        end
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            sync();
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_no_rsp: rsp_valid seen %0d cycles required 0", seen);
        end
        sync();
        rsp_ready = 0;
        issue(ALU_ADD, 32'd1, 32'd2, 32'd0, 0);
        wait_rsp(lat, bok);
        sync();
        flush = 1; rsp_ready = 1;
        sync();
        flush = 0; rsp_ready = 0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done: valid=%0b busy=%0b required 0/0", rsp_valid, busy);
        end
        sync();
    endtask

    task automatic test_rst_done();
        int lat; bit bok;
        rsp_ready = 0;
        issue(ALU_ADD, 32'd3, 32'd4, 32'd7, 0);
        wait_rsp(lat, bok);
        sync();
        rst = 1;
        sync();
        rst = 0;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, result, zero, busy} !== 35'd0) begin
            n_fail++;
            $display("FAIL rst_in_done: valid=%0b result=%08h zero=%0b busy=%0b required all 0",
                     rsp_valid, result, zero, busy);
        end
        sync();
    endtask

    task automatic test_step4();
        alu_op_e     ops [4] = '{ALU_SLL, ALU_SRA, ALU_SRL, ALU_SRL};
        logic [31:0] as  [4] = '{32'd3, 32'h8000_0000, 32'h0000_00F0, 32'hABCD_0123};
        logic [31:0] bs  [4] = '{32'd6, 32'd31, 32'd4, 32'd0};
        logic [31:0] ex  [4] = '{32'h0000_00C0, 32'hFFFF_FFFF, 32'h0000_000F, 32'hABCD_0123};
        int          el  [4] = '{3, 9, 2, 1};
        rsp_ready4 = 1;
        for (int i = 0; i < 4; i++) begin
            int lat; bit seen; bit bok;
            req_valid4 = 1; alu_op4 = ops[i]; operand_a4 = as[i]; operand_b4 = bs[i];
            @(negedge clk);
            n_cmp++;
            if (req_ready4 !== 1'b1) begin
                n_fail++;
                $display("FAIL step4_ready[%0d]: got %0b required 1", i, req_ready4);
            end
            sync();
            req_valid4 = 0; operand_a4 = $urandom; operand_b4 = $urandom;
            lat = 1; seen = 0; bok = 1;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (!busy4) bok = 0;
                if (rsp_valid4) begin seen = 1; break; end
                sync();
                lat++;
            end
            n_cmp++;
            if (!seen || lat !== el[i] || !bok) begin
                n_fail++;
                $display("FAIL step4_latency[%0d]: seen=%0b lat=%0d busy_ok=%0b required 1/%0d/1",
                         i, seen, lat, bok, el[i]);
            end
            n_cmp++;
            if (result4 !== ex[i] || zero4 !== (ex[i] == 32'd0)) begin
                n_fail++;
                $display("FAIL step4_result[%0d]: got %08h/%0b required %08h", i, result4, zero4, ex[i]);
            end
            sync();
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_alu_ops();
        test_shift();
        test_hold();
        test_back_to_back();
        test_flush();
        test_rst_done();
        test_step4();
        repeat (3) sync();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses outstanding required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
